// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_PER  = 2'b01,
        ARB_DONE = 2'b10
    } arb_state_t;

    localparam logic [1:0] WIDTH_WORD = 2'b10;

    // Next word address of a burst; wraps modulo 2**32 by construction.
    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU memory stage, the peripheral master, the arbiter
// and the data-memory wrapper.
//
// Handshake rules:
//   cpu_rd_en/cpu_wrt_en are taken in any cycle where cpu_stall=0; when stalled
//   the CPU holds the same access. per_req is a level held until the one-cycle
//   per_gnt pulse; per_wrt/per_addr/per_len are sampled in that grant cycle.
//   per_wrt_data is consumed in each cycle per_wrt_ack=1. Read data returns one
//   cycle after issue, qualified by the originator's *_rd_valid.
interface dmem_arbiter_if #(
    parameter int BURST_W = 4
) ();
    // CPU memory stage
    logic               cpu_rd_en;
    logic               cpu_wrt_en;
    logic               cpu_unsigned;
    logic [1:0]         cpu_width;
    logic [31:0]        cpu_addr;
    logic [31:0]        cpu_wrt_data;
    logic               cpu_stall;
    logic [31:0]        cpu_rd_data;
    logic               cpu_rd_valid;
    // Peripheral master
    logic               per_req;
    logic               per_wrt;
    logic [31:0]        per_addr;
    logic [BURST_W-1:0] per_len;
    logic               per_gnt;
    logic [31:0]        per_wrt_data;
    logic               per_wrt_ack;
    logic [31:0]        per_rd_data;
    logic               per_rd_valid;
    logic               per_done;
    // Data memory wrapper
    logic               mem_rd_en;
    logic               mem_wrt_en;
    logic               mem_unsigned;
    logic [1:0]         mem_width;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wrt_data;
    logic [31:0]        mem_rd_data;

    // Arbiter side
    modport slave (
        input  cpu_rd_en, cpu_wrt_en, cpu_unsigned, cpu_width, cpu_addr, cpu_wrt_data,
        output cpu_stall, cpu_rd_data, cpu_rd_valid,
        input  per_req, per_wrt, per_addr, per_len, per_wrt_data,
        output per_gnt, per_wrt_ack, per_rd_data, per_rd_valid, per_done,
        output mem_rd_en, mem_wrt_en, mem_unsigned, mem_width, mem_addr, mem_wrt_data,
        input  mem_rd_data
    );

    // Environment side (masters and memory)
    modport master (
        output cpu_rd_en, cpu_wrt_en, cpu_unsigned, cpu_width, cpu_addr, cpu_wrt_data,
        input  cpu_stall, cpu_rd_data, cpu_rd_valid,
        output per_req, per_wrt, per_addr, per_len, per_wrt_data,
        input  per_gnt, per_wrt_ack, per_rd_data, per_rd_valid, per_done,
        input  mem_rd_en, mem_wrt_en, mem_unsigned, mem_width, mem_addr, mem_wrt_data,
        output mem_rd_data
    );
endinterface

// File: rtl/dmem_starve_ctr.sv
// Saturating count of consecutive cycles the peripheral was denied.
module dmem_starve_ctr #(
    parameter int STARVE_LIM = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic hit
);
    localparam int W = $clog2(STARVE_LIM + 1);
    localparam logic [W-1:0] LIM_M1 = W'(STARVE_LIM - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign hit = (cnt_q == LIM_M1);

    // Clear wins over increment; hold at the limit once reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !hit) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU has priority, a peripheral master gets word
// bursts when the CPU is idle or after too many consecutive denials.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIM = 8,
    parameter int BURST_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_arbiter_if.slave bus,
    output arb_state_t dbg_state
);
    arb_state_t         state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [BURST_W-1:0] beats_q, beats_d;
    logic               wrt_q, wrt_d;
    logic               rd_pend_q, rd_pend_d;
    logic               rd_owner_q, rd_owner_d;   // 1 = peripheral issued the read

    logic        cpu_acc;
    logic        starve_hit;
    logic        per_gnt;
    logic        cpu_stall;
    logic        mem_rd_en;
    logic        mem_wrt_en;
    logic        mem_unsigned;
    logic [1:0]  mem_width;
    logic [31:0] mem_addr;
    logic [31:0] mem_wrt_data;
    logic        per_wrt_ack;
    logic        rd_issue_per;

    assign cpu_acc   = bus.cpu_rd_en | bus.cpu_wrt_en;
    assign dbg_state = state_q;

    dmem_starve_ctr #(
        .STARVE_LIM(STARVE_LIM)
    ) u_starve (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (bus.per_req & ~per_gnt & (state_q != ARB_PER)),
        .clr  (per_gnt),
        .hit  (starve_hit)
    );

    // Next-state, burst bookkeeping and memory port mux.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beats_d      = beats_q;
        wrt_d        = wrt_q;
        per_gnt      = 1'b0;
        mem_rd_en    = 1'b0;
        mem_wrt_en   = 1'b0;
        mem_unsigned = 1'b0;
        mem_width    = WIDTH_WORD;
        mem_addr     = '0;
        mem_wrt_data = '0;
        per_wrt_ack  = 1'b0;
        rd_issue_per = 1'b0;
        cpu_stall    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (bus.per_req && (!cpu_acc || starve_hit)) begin
                    per_gnt = 1'b1;
                    addr_d  = bus.per_addr;
                    beats_d = (bus.per_len == '0) ? BURST_W'(1) : bus.per_len;
                    wrt_d   = bus.per_wrt;
                    state_d = ARB_PER;
                end
            end
            ARB_PER: begin
                mem_addr = addr_q;
                if (wrt_q) begin
                    mem_wrt_en   = 1'b1;
                    per_wrt_ack  = 1'b1;
                    mem_wrt_data = bus.per_wrt_data;
                end else begin
                    mem_rd_en    = 1'b1;
                    rd_issue_per = 1'b1;
                end
                addr_d  = next_word_addr(addr_q);
                beats_d = beats_q - BURST_W'(1);
                if (beats_q <= BURST_W'(1)) begin
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
                // One-cycle gap so a held per_req cannot chain bursts.
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        // CPU owns the port outside PER and outside the grant cycle.
        if (state_q != ARB_PER && !per_gnt && cpu_acc) begin
            mem_addr     = bus.cpu_addr;
            mem_width    = bus.cpu_width;
            mem_unsigned = bus.cpu_unsigned;
            mem_wrt_en   = bus.cpu_wrt_en;
            mem_rd_en    = bus.cpu_rd_en & ~bus.cpu_wrt_en;   // store wins
            mem_wrt_data = bus.cpu_wrt_data;
        end

        cpu_stall = cpu_acc & ((state_q == ARB_PER) | per_gnt);

        // Keep every output quiet while reset is held, even with live inputs.
        if (!rst_n) begin
            per_gnt      = 1'b0;
            cpu_stall    = 1'b0;
            mem_rd_en    = 1'b0;
            mem_wrt_en   = 1'b0;
            mem_unsigned = 1'b0;
            mem_width    = WIDTH_WORD;
            mem_addr     = '0;
            mem_wrt_data = '0;
            per_wrt_ack  = 1'b0;
            rd_issue_per = 1'b0;
        end

        rd_pend_d  = mem_rd_en;
        rd_owner_d = rd_issue_per;
    end

    // FSM and burst registers; reset abandons any burst and pending read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            addr_q     <= '0;
            beats_q    <= '0;
            wrt_q      <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beats_q    <= beats_d;
            wrt_q      <= wrt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign bus.per_gnt      = per_gnt;
    assign bus.cpu_stall    = cpu_stall;
    assign bus.mem_rd_en    = mem_rd_en;
    assign bus.mem_wrt_en   = mem_wrt_en;
    assign bus.mem_unsigned = mem_unsigned;
    assign bus.mem_width    = mem_width;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wrt_data = mem_wrt_data;
    assign bus.per_wrt_ack  = per_wrt_ack;
    assign bus.per_done     = (state_q == ARB_DONE);

    // Route returning read data to whoever issued it; the other side sees zero.
    assign bus.cpu_rd_valid = rd_pend_q & ~rd_owner_q;
    assign bus.per_rd_valid = rd_pend_q &  rd_owner_q;
    assign bus.cpu_rd_data  = (rd_pend_q & ~rd_owner_q) ? bus.mem_rd_data : '0;
    assign bus.per_rd_data  = (rd_pend_q &  rd_owner_q) ? bus.mem_rd_data : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table for CPU-only traffic, hand sequences
// for bursts, starvation, address wrap and reset mid-burst; read returns are
// scored against queues filled when the accesses are driven.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int BURST_W    = 4;
    localparam int STARVE_LIM = 8;

    logic       clk;
    logic       rst_n;
    arb_state_t dbg_state;
    int         cyc;
    int         checks;
    int         errors;

    logic [31:0] cpu_exp_q[$];
    int          cpu_due_q[$];
    logic [31:0] per_exp_q[$];
    int          per_due_q[$];

    dmem_arbiter_if #(.BURST_W(BURST_W)) bus ();

    dmem_arbiter #(
        .STARVE_LIM(STARVE_LIM),
        .BURST_W   (BURST_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem_fn(bus.mem_addr);
        else               bus.mem_rd_data <= 32'hDEAD_BEEF;
    end

    // ---------------- driver / check tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_cpu(input logic [31:0] addr);
        cpu_exp_q.push_back(mem_fn(addr));
        cpu_due_q.push_back(cyc + 1);
    endtask

    task automatic push_per(input logic [31:0] addr);
        per_exp_q.push_back(mem_fn(addr));
        per_due_q.push_back(cyc + 1);
    endtask

    task automatic cpu_idle();
        bus.cpu_rd_en    = 1'b0;
        bus.cpu_wrt_en   = 1'b0;
        bus.cpu_unsigned = 1'b0;
        bus.cpu_width    = 2'b10;
        bus.cpu_addr     = '0;
        bus.cpu_wrt_data = '0;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (cpu_due_q.size() > 0 && cpu_due_q[0] == cyc) begin
            chk("cpu_rd_valid", {31'b0, bus.cpu_rd_valid}, 32'd1);
            chk("cpu_rd_data", bus.cpu_rd_data, cpu_exp_q[0]);
            void'(cpu_exp_q.pop_front());
            void'(cpu_due_q.pop_front());
        end else if (bus.cpu_rd_valid) begin
            chk("cpu_rd_valid_unexpected", {31'b0, bus.cpu_rd_valid}, 32'd0);
        end
        if (per_due_q.size() > 0 && per_due_q[0] == cyc) begin
            chk("per_rd_valid", {31'b0, bus.per_rd_valid}, 32'd1);
            chk("per_rd_data", bus.per_rd_data, per_exp_q[0]);
            void'(per_exp_q.pop_front());
            void'(per_due_q.pop_front());
        end else if (bus.per_rd_valid) begin
            chk("per_rd_valid_unexpected", {31'b0, bus.per_rd_valid}, 32'd0);
        end
    end

    // ---------------- CPU-only vector table ----------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic        uns;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_stall;
        logic        exp_rd;
        logic        exp_wr;
    } vec_t;

    vec_t vecs[5];

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        cpu_idle();
        bus.per_req      = 1'b1;   // live request must not leak through reset
        bus.per_wrt      = 1'b0;
        bus.per_addr     = '0;
        bus.per_len      = '0;
        bus.per_wrt_data = '0;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 2'b10, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0103, 32'h0000_00AB, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 2'b01, 32'h0000_010A, 32'h0000_BEEF, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_0107, 32'h0,         1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_per_gnt",   {31'b0, bus.per_gnt},    32'd0);
        chk("rst_cpu_stall", {31'b0, bus.cpu_stall},  32'd0);
        chk("rst_mem_rd_en", {31'b0, bus.mem_rd_en},  32'd0);
        chk("rst_mem_wrt",   {31'b0, bus.mem_wrt_en}, 32'd0);
        chk("rst_mem_width", {30'b0, bus.mem_width},  32'd2);
        chk("rst_per_done",  {31'b0, bus.per_done},   32'd0);
        chk("rst_state",     32'(dbg_state),          32'(ARB_IDLE));
        tick();
        rst_n       = 1'b1;
        bus.per_req = 1'b0;

        // CPU-only traffic from the table
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.cpu_rd_en    = vecs[i].rd;
            bus.cpu_wrt_en   = vecs[i].wr;
            bus.cpu_unsigned = vecs[i].uns;
            bus.cpu_width    = vecs[i].width;
            bus.cpu_addr     = vecs[i].addr;
            bus.cpu_wrt_data = vecs[i].wdata;
            if (vecs[i].exp_rd) push_cpu(vecs[i].addr);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), {31'b0, bus.cpu_stall},  {31'b0, vecs[i].exp_stall});
            chk($sformatf("v%0d_rd_en", i), {31'b0, bus.mem_rd_en},  {31'b0, vecs[i].exp_rd});
            chk($sformatf("v%0d_wr_en", i), {31'b0, bus.mem_wrt_en}, {31'b0, vecs[i].exp_wr});
            if (vecs[i].exp_rd || vecs[i].exp_wr) begin
                chk($sformatf("v%0d_addr", i),  bus.mem_addr,            vecs[i].addr);
                chk($sformatf("v%0d_width", i), {30'b0, bus.mem_width},  {30'b0, vecs[i].width});
                chk($sformatf("v%0d_uns", i),   {31'b0, bus.mem_unsigned}, {31'b0, vecs[i].uns});
            end
            if (vecs[i].exp_wr) chk($sformatf("v%0d_wdata", i), bus.mem_wrt_data, vecs[i].wdata);
        end
        tick();
        cpu_idle();

        // Idle grant: read burst of 3 at 0x200
        tick();
        bus.per_req  = 1'b1;
        bus.per_wrt  = 1'b0;
        bus.per_addr = 32'h0000_0200;
        bus.per_len  = 4'd3;
        @(negedge clk);
        chk("ig_gnt",   {31'b0, bus.per_gnt},   32'd1);
        chk("ig_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            bus.per_req  = 1'b0;
            bus.per_addr = 32'h0000_BAD0;
            push_per(32'h0000_0200 + 32'(4 * k));
            @(negedge clk);
            chk($sformatf("ig_b%0d_rd", k),   {31'b0, bus.mem_rd_en}, 32'd1);
            chk($sformatf("ig_b%0d_addr", k), bus.mem_addr,           32'h0000_0200 + 32'(4 * k));
            chk($sformatf("ig_b%0d_w", k),    {30'b0, bus.mem_width}, 32'd2);
            chk($sformatf("ig_b%0d_gnt", k),  {31'b0, bus.per_gnt},   32'd0);
            chk($sformatf("ig_b%0d_done", k), {31'b0, bus.per_done},  32'd0);
        end
        tick();
        @(negedge clk);
        chk("ig_done",   {31'b0, bus.per_done}, 32'd1);
        chk("ig_state",  32'(dbg_state),        32'(ARB_DONE));
        tick();
        @(negedge clk);
        chk("ig_done_clr", {31'b0, bus.per_done}, 32'd0);
        chk("ig_idle",     32'(dbg_state),        32'(ARB_IDLE));

        // Starvation: CPU loads every cycle, grant forced on the 8th request cycle
        for (int i = 1; i <= STARVE_LIM; i++) begin
            tick();
            bus.per_req   = 1'b1;
            bus.per_wrt   = 1'b0;
            bus.per_addr  = 32'h0000_0300;
            bus.per_len   = 4'd1;
            bus.cpu_rd_en = 1'b1;
            bus.cpu_addr  = 32'h0000_0400 + 32'(4 * i);
            if (i < STARVE_LIM) push_cpu(bus.cpu_addr);
            @(negedge clk);
            chk($sformatf("st_c%0d_gnt", i),   {31'b0, bus.per_gnt},   {31'b0, (i == STARVE_LIM)});
            chk($sformatf("st_c%0d_stall", i), {31'b0, bus.cpu_stall}, {31'b0, (i == STARVE_LIM)});
        end
        tick();
        bus.per_req = 1'b0;
        push_per(32'h0000_0300);
        @(negedge clk);
        chk("st_per_stall", {31'b0, bus.cpu_stall}, 32'd1);
        chk("st_per_addr",  bus.mem_addr,           32'h0000_0300);
        chk("st_per_rd",    {31'b0, bus.mem_rd_en}, 32'd1);
        tick();
        push_cpu(bus.cpu_addr);
        @(negedge clk);
        chk("st_done_stall", {31'b0, bus.cpu_stall}, 32'd0);
        chk("st_done_pulse", {31'b0, bus.per_done},  32'd1);
        chk("st_done_addr",  bus.mem_addr,           32'h0000_0420);
        tick();
        cpu_idle();

        // Write burst of 2 wrapping at the top of the address space
        tick();
        bus.per_req  = 1'b1;
        bus.per_wrt  = 1'b1;
        bus.per_addr = 32'hFFFF_FFFC;
        bus.per_len  = 4'd2;
        @(negedge clk);
        chk("wb_gnt", {31'b0, bus.per_gnt},     32'd1);
        chk("wb_ack", {31'b0, bus.per_wrt_ack}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            bus.per_req      = 1'b0;
            bus.per_addr     = '0;
            bus.per_wrt_data = (k == 0) ? 32'h1111_0000 : 32'h2222_0000;
            bus.cpu_wrt_en   = 1'b1;
            bus.cpu_addr     = 32'h0000_1234;
            bus.cpu_wrt_data = 32'hCCCC_CCCC;
            @(negedge clk);
            chk($sformatf("wb_b%0d_wr", k),    {31'b0, bus.mem_wrt_en},  32'd1);
            chk($sformatf("wb_b%0d_rd", k),    {31'b0, bus.mem_rd_en},   32'd0);
            chk($sformatf("wb_b%0d_addr", k),  bus.mem_addr,             (k == 0) ? 32'hFFFF_FFFC : 32'h0);
            chk($sformatf("wb_b%0d_data", k),  bus.mem_wrt_data,         bus.per_wrt_data);
            chk($sformatf("wb_b%0d_ack", k),   {31'b0, bus.per_wrt_ack}, 32'd1);
            chk($sformatf("wb_b%0d_stall", k), {31'b0, bus.cpu_stall},   32'd1);
        end
        tick();
        @(negedge clk);
        chk("wb_done",      {31'b0, bus.per_done},    32'd1);
        chk("wb_done_ack",  {31'b0, bus.per_wrt_ack}, 32'd0);
        chk("wb_cpu_stall", {31'b0, bus.cpu_stall},   32'd0);
        chk("wb_cpu_addr",  bus.mem_addr,             32'h0000_1234);
        chk("wb_cpu_data",  bus.mem_wrt_data,         32'hCCCC_CCCC);
        tick();
        cpu_idle();

        // Zero length counts as a single beat
        tick();
        bus.per_req  = 1'b1;
        bus.per_wrt  = 1'b0;
        bus.per_addr = 32'h0000_0500;
        bus.per_len  = 4'd0;
        @(negedge clk);
        chk("z_gnt", {31'b0, bus.per_gnt}, 32'd1);
        tick();
        bus.per_req = 1'b0;
        push_per(32'h0000_0500);
        @(negedge clk);
        chk("z_addr",  bus.mem_addr,   32'h0000_0500);
        chk("z_state", 32'(dbg_state), 32'(ARB_PER));
        tick();
        @(negedge clk);
        chk("z_done",  {31'b0, bus.per_done},  32'd1);
        chk("z_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);

        // Reset during beat 2 of a 4-beat read burst
        tick();
        bus.per_req  = 1'b1;
        bus.per_addr = 32'h0000_0600;
        bus.per_len  = 4'd4;
        @(negedge clk);
        chk("rb_gnt", {31'b0, bus.per_gnt}, 32'd1);
        tick();
        bus.per_req = 1'b0;
        push_per(32'h0000_0600);
        tick();
        bus.cpu_rd_en = 1'b1;
        bus.cpu_addr  = 32'h0000_0700;
        @(negedge clk);
        chk("rb_b2_addr",  bus.mem_addr,           32'h0000_0604);
        chk("rb_b2_stall", {31'b0, bus.cpu_stall}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rb_rst_state", 32'(dbg_state),           32'(ARB_IDLE));
        chk("rb_rst_stall", {31'b0, bus.cpu_stall},   32'd0);
        chk("rb_rst_rd_en", {31'b0, bus.mem_rd_en},   32'd0);
        chk("rb_rst_addr",  bus.mem_addr,             32'h0);
        chk("rb_rst_prv",   {31'b0, bus.per_rd_valid}, 32'd0);
        chk("rb_rst_done",  {31'b0, bus.per_done},    32'd0);
        tick();
        rst_n = 1'b1;
        push_cpu(32'h0000_0700);
        @(negedge clk);
        chk("rb_post_state", 32'(dbg_state),           32'(ARB_IDLE));
        chk("rb_post_stall", {31'b0, bus.cpu_stall},   32'd0);
        chk("rb_post_rd",    {31'b0, bus.mem_rd_en},   32'd1);
        chk("rb_post_addr",  bus.mem_addr,             32'h0000_0700);
        chk("rb_post_done",  {31'b0, bus.per_done},    32'd0);
        tick();
        cpu_idle();
        repeat (3) tick();

        chk("cpu_q_empty", 32'(cpu_exp_q.size()), 32'd0);
        chk("per_q_empty", 32'(per_exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
